a1csa_pipe: RTL and testbench

- Parametrised, pipelined successor to the hierarchical add-one carry-select adder family.
- Splits an N-bit add into SEG-bit carry-select segments and places one pipeline register stage per segment, so the carry travels one segment per clock.
- Adds valid/ready flow control plus group generate/propagate and carry-out.
- Sits in datapaths that need a wide adder at high clock rate with back-pressure.

---
 rtl/a1csa_pipe.sv | 103 ++++++++++
 tb/tb_a1csa_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/a1csa_pipe.sv
// a1csa_pipe: pipelined add-one carry-select adder, one SEG-bit segment per stage, valid/ready flow control.
// Optional subtract mode is enabled by defining A1CSA_PIPE_SUB_EN.
module a1csa_pipe #(
  parameter int N   = 64,
  parameter int SEG = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         cin,
`ifdef A1CSA_PIPE_SUB_EN
  input  logic         sub,
`endif
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         gen,
  output logic         prop
);
  localparam int STAGES = N / SEG;
  logic         en;
  logic [N-1:0] b_eff;
  logic         c_eff;
  logic [N-1:0] ra [STAGES];
  logic [N-1:0] rb [STAGES];
  logic [N-1:0] rs [STAGES];
  logic         rv [STAGES];
  logic         rc [STAGES];
  logic         rg [STAGES];
  logic         rp [STAGES];
  assign en       = !out_valid | out_ready;
  assign in_ready = en;
`ifdef A1CSA_PIPE_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | cin;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif
  for (genvar i = 0; i < STAGES; i++) begin : stg
    logic [N-1:0]   a_in, b_in, s_in, s_nx;
    logic           v_in, c_in, g_in, p_in;
    logic [SEG-1:0] sa, sb, sum1;
    logic [SEG:0]   sum0;
    logic           gk, pk;
    if (i == 0) begin : head
      assign a_in = a;
      assign b_in = b_eff;
      assign s_in = '0;
      assign v_in = in_valid;
      assign c_in = c_eff;
      assign g_in = 1'b0;
      assign p_in = 1'b1;
    end else begin : body
      assign a_in = ra[i-1];
      assign b_in = rb[i-1];
      assign s_in = rs[i-1];
      assign v_in = rv[i-1];
      assign c_in = rc[i-1];
      assign g_in = rg[i-1];
      assign p_in = rp[i-1];
    end
    assign sa   = a_in[i*SEG +: SEG];
    assign sb   = b_in[i*SEG +: SEG];
    assign sum0 = {1'b0, sa} + {1'b0, sb};
    assign sum1 = sa + sb + SEG'(1);
    assign gk   = sum0[SEG];
    assign pk   = &(sa ^ sb);
    // insert this segment's carry-selected sum into the beat's accumulated sum
    always_comb begin
      s_nx = s_in;
      s_nx[i*SEG +: SEG] = c_in ? sum1 : sum0[SEG-1:0];
    end
    // stage register: advances only on global enable, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        rv[i] <= 1'b0;
        ra[i] <= '0;
        rb[i] <= '0;
        rs[i] <= '0;
        rc[i] <= 1'b0;
        rg[i] <= 1'b0;
        rp[i] <= 1'b0;
      end else if (en) begin
        rv[i] <= v_in;
        ra[i] <= a_in;
        rb[i] <= b_in;
        rs[i] <= s_nx;
        rc[i] <= gk | (pk & c_in);
        rg[i] <= gk | (pk & g_in);
        rp[i] <= pk & p_in;
      end
  end
  assign out_valid = rv[STAGES-1];
  assign s         = rs[STAGES-1];
  assign cout      = rc[STAGES-1];
  assign gen       = rg[STAGES-1];
  assign prop      = rp[STAGES-1];
endmodule

// File: tb/tb_a1csa_pipe.sv
// tb_a1csa_pipe: directed + random scoreboard bench for a1csa_pipe (N=64, SEG=16).
module tb_a1csa_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] s;
  logic        cout, gen, prop;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        lat_en = 1'b1;
  typedef struct {
    logic [63:0] s;
    logic        c, g, p, lat;
    int          cyc;
  } exp_t;
  exp_t q[$];

  a1csa_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .cin(cin),
`ifdef A1CSA_PIPE_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .gen(gen), .prop(prop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: sample handshakes mid-cycle, well away from the rising edge
  always @(negedge clk) begin
    #2;
    if (!rst_n) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_s", s, e.s);
          chk("sb_cout", cout, e.c);
          chk("sb_gen", gen, e.g);
          chk("sb_prop", prop, e.p);
          if (e.lat) chk("sb_latency", cyc - e.cyc, 4);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        logic [63:0] be;
        logic        ce;
        logic [64:0] full, raw;
        be   = sub ? ~b : b;
        ce   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, be} + {64'd0, ce};
        raw  = {1'b0, a} + {1'b0, be};
        e.s  = full[63:0];
        e.c  = full[64];
        e.g  = raw[64];
        e.p  = &(a ^ be);
        e.lat = lat_en;
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic c, input logic sb);
    int t = 0;
    @(negedge clk);
    a = x; b = y; cin = c; sub = sb; in_valid = 1'b1;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
  endtask

  task automatic expect_out(input string tag, input logic [63:0] es, input logic ec, input logic eg,
                            input logic ep, input int elat);
    int k = 0;
    @(negedge clk);
    in_valid = 1'b0; sub = 1'b0;
    k = 1;
    #1;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_s"}, s, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_gen"}, gen, eg);
      chk({tag, "_prop"}, prop, ep);
      if (elat > 0) chk({tag, "_latency"}, k, elat);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0; sub = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_gen", gen, 0);
    chk("rst_prop", prop, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    // single beat, all-ones + carry-in wraps to zero
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    expect_out("single", 64'h0, 1'b1, 1'b0, 1'b1, 4);
    idle(4);
    // carry ripples through every segment boundary
    send(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    expect_out("carry", 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4);
    idle(4);
    // full propagate with no generate: cin decides cout
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
    expect_out("prop", 64'h0, 1'b1, 1'b0, 1'b1, 4);
    idle(4);
    // back-to-back random stream
    for (int i = 0; i < 100; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0);
    idle(8);
    chk("stream_drain", q.size(), 0);
    // back-pressure: downstream stalls for 6 cycles while beats keep coming
    lat_en = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0);
      begin
        @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle(10);
    chk("bp_drain", q.size(), 0);
    lat_en = 1'b1;
`ifdef A1CSA_PIPE_SUB_EN
    send(64'd5, 64'd7, 1'b0, 1'b1);
    expect_out("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 4);
    idle(4);
    send(64'd7, 64'd5, 1'b0, 1'b1);
    expect_out("sub_pos", 64'd2, 1'b1, 1'b1, 1'b0, 4);
    idle(4);
`endif
    // reset with three beats in flight
    send(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0, 1'b0);
    send(64'h2, 64'h3, 1'b1, 1'b0);
    send(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_s", s, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_gen", gen, 0);
    chk("mid_rst_prop", prop, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("post_rst_valid", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
